// File: rtl/mmu_pkg.sv
// Shared definitions for the TLB-based MMU: segment codes, TLB entry layout,
// translation result record and exception codes.
package mmu_pkg;

  localparam logic [2:0] KSEG0 = 3'b100;
  localparam logic [2:0] KSEG1 = 3'b101;
  localparam logic [2:0] C_UNCACHED = 3'd2;

  localparam int VPN2_W       = 19;
  localparam int ENTRY_ASID_W = 8;
  localparam int PFN_W        = 20;
  localparam int PAGE_W       = PFN_W + 5;
  localparam int ENTRY_W      = VPN2_W + ENTRY_ASID_W + 1 + 2 * PAGE_W;

  localparam logic [4:0] EXC_MOD  = 5'd1;
  localparam logic [4:0] EXC_TLBL = 5'd2;
  localparam logic [4:0] EXC_TLBS = 5'd3;

  typedef struct packed {
    logic [PFN_W-1:0] pfn;
    logic [2:0]       c;
    logic             d;
    logic             v;
  } page_t;

  // Packed layout matches the 78-bit CP0 write/read bus, MSB first.
  typedef struct packed {
    logic [VPN2_W-1:0]       vpn2;
    logic [ENTRY_ASID_W-1:0] asid;
    logic                    g;
    page_t                   p0;
    page_t                   p1;
  } tlb_entry_t;

  typedef struct packed {
    logic [31:0] paddr;
    logic        uncached;
    logic        refill;
    logic        invalid;
    logic        modified;
  } xlat_t;

endpackage

// File: rtl/tlb_mmu_if.sv
// Pipeline/CP0 side bundle of the MMU: instruction and data lookup channels
// plus TLB write, read and probe ports.
interface tlb_mmu_if #(
  parameter int TLB_ENTRIES = 16,
  parameter int ASID_W      = 8
);
  localparam int IDX_W = $clog2(TLB_ENTRIES);

  logic [ASID_W-1:0] asid;

  logic              inst_req;
  logic [31:0]       inst_vaddr;
  logic              inst_ok;
  logic [31:0]       inst_paddr;
  logic              inst_uncached;
  logic              inst_refill;
  logic              inst_invalid;

  logic              data_req;
  logic              data_wr;
  logic [31:0]       data_vaddr;
  logic              data_ok;
  logic [31:0]       data_paddr;
  logic              data_uncached;
  logic              data_refill;
  logic              data_invalid;
  logic              data_modified;

  logic              tlb_we;
  logic [IDX_W-1:0]  tlb_widx;
  logic [77:0]       tlb_wentry;
  logic [IDX_W-1:0]  tlbr_idx;
  logic [77:0]       tlbr_entry;
  logic              tlbp_req;
  logic [18:0]       probe_vpn2;
  logic              tlbp_ok;
  logic              tlbp_miss;
  logic [IDX_W-1:0]  tlbp_idx;

  modport master (
    output asid, inst_req, inst_vaddr, data_req, data_wr, data_vaddr,
           tlb_we, tlb_widx, tlb_wentry, tlbr_idx, tlbp_req, probe_vpn2,
    input  inst_ok, inst_paddr, inst_uncached, inst_refill, inst_invalid,
           data_ok, data_paddr, data_uncached, data_refill, data_invalid, data_modified,
           tlbr_entry, tlbp_ok, tlbp_miss, tlbp_idx
  );

  modport slave (
    input  asid, inst_req, inst_vaddr, data_req, data_wr, data_vaddr,
           tlb_we, tlb_widx, tlb_wentry, tlbr_idx, tlbp_req, probe_vpn2,
    output inst_ok, inst_paddr, inst_uncached, inst_refill, inst_invalid,
           data_ok, data_paddr, data_uncached, data_refill, data_invalid, data_modified,
           tlbr_entry, tlbp_ok, tlbp_miss, tlbp_idx
  );

endinterface

// File: rtl/tlb_lookup.sv
// Combinational fully-associative TLB match: lowest matching index wins,
// then the even/odd page half is selected by va[12].
module tlb_lookup
  import mmu_pkg::*;
#(
  parameter int TLB_ENTRIES = 16,
  parameter int ASID_W      = 8
) (
  input  tlb_entry_t                       entries [TLB_ENTRIES],
  input  logic [VPN2_W-1:0]                vpn2,
  input  logic                             odd,
  input  logic [ASID_W-1:0]                asid,
  output logic                             hit,
  output logic [$clog2(TLB_ENTRIES)-1:0]   idx,
  output page_t                            page
);
  localparam int IDX_W = $clog2(TLB_ENTRIES);

  // Scan from the top so the lowest matching index is the last one assigned.
  always_comb begin
    hit  = 1'b0;
    idx  = '0;
    page = '0;
    for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
      if (entries[i].vpn2 == vpn2 &&
          (entries[i].g || entries[i].asid == ENTRY_ASID_W'(asid))) begin
        hit  = 1'b1;
        idx  = IDX_W'(i);
        page = odd ? entries[i].p1 : entries[i].p0;
      end
    end
  end

endmodule

// File: rtl/tlb_mmu.sv
// Address translator: kseg0/kseg1 direct-mapped, other segments through a
// software-managed dual-page TLB; one-cycle lookup, CP0 write/read/probe.
module tlb_mmu
  import mmu_pkg::*;
#(
  parameter int TLB_ENTRIES = 16,
  parameter int ASID_W      = 8
) (
  input  logic     clk,
  input  logic     resetn,
  tlb_mmu_if.slave bus
);
  localparam int IDX_W = $clog2(TLB_ENTRIES);

  tlb_entry_t       tlb_q [TLB_ENTRIES];

  logic             inst_hit, data_hit, probe_hit;
  logic [IDX_W-1:0] inst_idx_unused, data_idx_unused, probe_idx;
  page_t            inst_page, data_page, probe_page_unused;
  xlat_t            inst_res, data_res;

  logic             inst_vld_p1, data_vld_p1, probe_vld_p1;
  xlat_t            inst_res_p1, data_res_p1;
  logic             probe_miss_p1;
  logic [IDX_W-1:0] probe_idx_p1;
  logic [77:0]      tlbr_p1;
  logic             inst_mod_unused;

  function automatic xlat_t xlat(logic [31:0] va, logic wr, logic hit, page_t pg);
    xlat_t r;
    r = '0;
    if (va[31:29] == KSEG0 || va[31:29] == KSEG1) begin
      r.paddr    = {3'b000, va[28:0]};
      r.uncached = (va[31:29] == KSEG1);
    end else if (!hit) begin
      r.refill = 1'b1;
    end else if (!pg.v) begin
      r.invalid = 1'b1;
    end else if (wr && !pg.d) begin
      r.modified = 1'b1;
    end else begin
      r.paddr    = {pg.pfn, va[11:0]};
      r.uncached = (pg.c == C_UNCACHED);
    end
    return r;
  endfunction

  tlb_lookup #(.TLB_ENTRIES(TLB_ENTRIES), .ASID_W(ASID_W)) u_inst_lkp (
    .entries(tlb_q), .vpn2(bus.inst_vaddr[31:13]), .odd(bus.inst_vaddr[12]),
    .asid(bus.asid), .hit(inst_hit), .idx(inst_idx_unused), .page(inst_page)
  );

  tlb_lookup #(.TLB_ENTRIES(TLB_ENTRIES), .ASID_W(ASID_W)) u_data_lkp (
    .entries(tlb_q), .vpn2(bus.data_vaddr[31:13]), .odd(bus.data_vaddr[12]),
    .asid(bus.asid), .hit(data_hit), .idx(data_idx_unused), .page(data_page)
  );

  tlb_lookup #(.TLB_ENTRIES(TLB_ENTRIES), .ASID_W(ASID_W)) u_probe_lkp (
    .entries(tlb_q), .vpn2(bus.probe_vpn2), .odd(1'b0),
    .asid(bus.asid), .hit(probe_hit), .idx(probe_idx), .page(probe_page_unused)
  );

  assign inst_res = xlat(bus.inst_vaddr, 1'b0, inst_hit, inst_page);
  assign data_res = xlat(bus.data_vaddr, bus.data_wr, data_hit, data_page);

  // Entry array: lookups in the write cycle still see the old contents.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < TLB_ENTRIES; i++) tlb_q[i] <= '0;
    end else if (bus.tlb_we) begin
      tlb_q[bus.tlb_widx] <= tlb_entry_t'(bus.tlb_wentry);
    end
  end

  // ---- stage p0 -> p1: lookup, probe and read results ----
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      inst_vld_p1   <= 1'b0;
      data_vld_p1   <= 1'b0;
      probe_vld_p1  <= 1'b0;
      inst_res_p1   <= '0;
      data_res_p1   <= '0;
      probe_miss_p1 <= 1'b0;
      probe_idx_p1  <= '0;
      tlbr_p1       <= '0;
    end else begin
      inst_vld_p1  <= bus.inst_req;
      data_vld_p1  <= bus.data_req;
      probe_vld_p1 <= bus.tlbp_req;
      if (bus.inst_req) inst_res_p1 <= inst_res;
      if (bus.data_req) data_res_p1 <= data_res;
      if (bus.tlbp_req) begin
        probe_miss_p1 <= !probe_hit;
        probe_idx_p1  <= probe_idx;
      end
      tlbr_p1 <= tlb_q[bus.tlbr_idx];
    end
  end

  assign bus.inst_ok       = inst_vld_p1;
  assign bus.inst_paddr    = inst_res_p1.paddr;
  assign bus.inst_uncached = inst_res_p1.uncached;
  assign bus.inst_refill   = inst_res_p1.refill;
  assign bus.inst_invalid  = inst_res_p1.invalid;
  assign inst_mod_unused   = inst_res_p1.modified;

  assign bus.data_ok       = data_vld_p1;
  assign bus.data_paddr    = data_res_p1.paddr;
  assign bus.data_uncached = data_res_p1.uncached;
  assign bus.data_refill   = data_res_p1.refill;
  assign bus.data_invalid  = data_res_p1.invalid;
  assign bus.data_modified = data_res_p1.modified;

  assign bus.tlbr_entry = tlbr_p1;
  assign bus.tlbp_ok    = probe_vld_p1;
  assign bus.tlbp_miss  = probe_miss_p1;
  assign bus.tlbp_idx   = probe_idx_p1;

endmodule

// File: tb/tb_tlb_mmu.sv
// Scoreboard bench for tlb_mmu: directed requests push expected results,
// a monitor pops and compares on every ok pulse.
module tb_tlb_mmu;

  typedef struct packed {
    logic [31:0] paddr;
    logic        unc;
    logic        refill;
    logic        invalid;
    logic        modified;
  } exp_t;

  typedef struct packed {
    logic       miss;
    logic [3:0] idx;
  } pexp_t;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  int   tests = 0;
  int   fails = 0;

  exp_t  inst_q[$];
  exp_t  data_q[$];
  pexp_t probe_q[$];

  tlb_mmu_if #(.TLB_ENTRIES(16), .ASID_W(8)) bus ();

  tlb_mmu #(.TLB_ENTRIES(16), .ASID_W(8)) dut (
    .clk(clk), .resetn(resetn), .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [77:0] mk(logic [18:0] vpn2, logic [7:0] asid, logic g,
                                     logic [19:0] pfn0, logic [2:0] c0, logic d0, logic v0,
                                     logic [19:0] pfn1, logic [2:0] c1, logic d1, logic v1);
    return {vpn2, asid, g, pfn0, c0, d0, v0, pfn1, c1, d1, v1};
  endfunction

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    bus.inst_req = 1'b0;
    bus.data_req = 1'b0;
    bus.data_wr  = 1'b0;
    bus.tlb_we   = 1'b0;
    bus.tlbp_req = 1'b0;
  endtask

  task automatic req_inst(logic [31:0] va, exp_t e);
    bus.inst_req = 1'b1;
    bus.inst_vaddr = va;
    inst_q.push_back(e);
  endtask

  task automatic req_data(logic [31:0] va, logic wr, exp_t e, bit expect_ok);
    bus.data_req = 1'b1;
    bus.data_wr = wr;
    bus.data_vaddr = va;
    if (expect_ok) data_q.push_back(e);
  endtask

  task automatic req_probe(logic [18:0] vpn2, pexp_t e);
    bus.tlbp_req = 1'b1;
    bus.probe_vpn2 = vpn2;
    probe_q.push_back(e);
  endtask

  task automatic wr_entry(logic [3:0] idx, logic [77:0] ent);
    bus.tlb_we = 1'b1;
    bus.tlb_widx = idx;
    bus.tlb_wentry = ent;
  endtask

  // Monitor: compare every ok pulse against the head of its queue.
  initial begin
    exp_t  got, e;
    pexp_t pgot, pe;
    forever begin
      @(posedge clk);
      #1;
      if (bus.inst_ok) begin
        got = {bus.inst_paddr, bus.inst_uncached, bus.inst_refill, bus.inst_invalid, 1'b0};
        if (inst_q.size() == 0) check("inst_unexpected_ok", 64'(got), 64'(0));
        else begin e = inst_q.pop_front(); check("inst_result", 64'(got), 64'(e)); end
      end
      if (bus.data_ok) begin
        got = {bus.data_paddr, bus.data_uncached, bus.data_refill, bus.data_invalid,
               bus.data_modified};
        if (data_q.size() == 0) check("data_unexpected_ok", 64'(got), 64'(0));
        else begin e = data_q.pop_front(); check("data_result", 64'(got), 64'(e)); end
      end
      if (bus.tlbp_ok) begin
        pgot = {bus.tlbp_miss, bus.tlbp_idx};
        if (probe_q.size() == 0) check("probe_unexpected_ok", 64'(pgot), 64'(0));
        else begin pe = probe_q.pop_front(); check("probe_result", 64'(pgot), 64'(pe)); end
      end
    end
  end

  initial begin
    logic [77:0] e3_old, e3_new;
    bus.asid = 8'd5;
    bus.inst_req = 1'b0; bus.inst_vaddr = '0;
    bus.data_req = 1'b0; bus.data_wr = 1'b0; bus.data_vaddr = '0;
    bus.tlb_we = 1'b0; bus.tlb_widx = '0; bus.tlb_wentry = '0;
    bus.tlbr_idx = 4'd3; bus.tlbp_req = 1'b0; bus.probe_vpn2 = '0;

    #3 resetn = 1'b0;
    tick(); tick();
    resetn = 1'b1;
    tick();
    check("reset_outputs",
          64'({bus.inst_ok, bus.data_ok, bus.tlbp_ok, bus.tlbp_miss, bus.tlbp_idx,
               bus.inst_paddr, bus.data_paddr}), 64'(0));
    check("reset_tlbr", 64'(bus.tlbr_entry), 64'(0));

    // Unmapped segments, back to back.
    tick(); req_inst(32'h9FC0_0000, '{32'h1FC0_0000, 1'b0, 1'b0, 1'b0, 1'b0});
    tick(); req_inst(32'hBFC0_0004, '{32'h1FC0_0004, 1'b1, 1'b0, 1'b0, 1'b0});
            req_data(32'hA000_1000, 1'b1, '{32'h0000_1000, 1'b1, 1'b0, 1'b0, 1'b0}, 1'b1);

    e3_old = mk(19'h00040, 8'd5, 1'b0, 20'h12345, 3'd3, 1'b1, 1'b1,
                20'h0ABCD, 3'd2, 1'b1, 1'b0);
    e3_new = mk(19'h00040, 8'd5, 1'b0, 20'h54321, 3'd3, 1'b1, 1'b1,
                20'h0ABCD, 3'd2, 1'b1, 1'b0);
    tick(); wr_entry(4'd3, e3_old);
    tick(); wr_entry(4'd4, mk(19'h00041, 8'd5, 1'b0, 20'h22222, 3'd2, 1'b0, 1'b1,
                              20'h0, 3'd0, 1'b0, 1'b0));

    // Mapped lookups: hit, ASID miss, invalid, modified, uncached, clean store.
    tick(); req_data(32'h0008_0ABC, 1'b0, '{32'h1234_5ABC, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b1);
    tick(); bus.asid = 8'd6;
            req_data(32'h0008_0ABC, 1'b0, '{32'h0, 1'b0, 1'b1, 1'b0, 1'b0}, 1'b1);
    tick(); bus.asid = 8'd5;
            req_data(32'h0008_1ABC, 1'b0, '{32'h0, 1'b0, 1'b0, 1'b1, 1'b0}, 1'b1);
    tick(); req_data(32'h0008_2010, 1'b1, '{32'h0, 1'b0, 1'b0, 1'b0, 1'b1}, 1'b1);
    tick(); req_data(32'h0008_2010, 1'b0, '{32'h2222_2010, 1'b1, 1'b0, 1'b0, 1'b0}, 1'b1);
    tick(); req_data(32'h0008_0ABC, 1'b1, '{32'h1234_5ABC, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b1);
    // Both channels hit entry 3 in the same cycle.
    tick(); req_inst(32'h0008_0ABC, '{32'h1234_5ABC, 1'b0, 1'b0, 1'b0, 1'b0});
            req_data(32'h0008_1ABC, 1'b0, '{32'h0, 1'b0, 1'b0, 1'b1, 1'b0}, 1'b1);

    // Write concurrent with lookup and read: old contents, then new.
    tick(); wr_entry(4'd3, e3_new);
            req_inst(32'h0008_0ABC, '{32'h1234_5ABC, 1'b0, 1'b0, 1'b0, 1'b0});
    tick(); check("tlbr_old_on_write", 64'(bus.tlbr_entry), 64'(e3_old));
            req_inst(32'h0008_0ABC, '{32'h5432_1ABC, 1'b0, 1'b0, 1'b0, 1'b0});
    tick(); check("tlbr_new_after_write", 64'(bus.tlbr_entry), 64'(e3_new));

    // Duplicate global VPN2 at idx7 and idx2: lowest index wins.
    wr_entry(4'd7, mk(19'h00100, 8'd0, 1'b1, 20'h0BBBB, 3'd3, 1'b1, 1'b1,
                      20'h0, 3'd0, 1'b0, 1'b0));
    tick(); wr_entry(4'd2, mk(19'h00100, 8'd0, 1'b1, 20'h0AAAA, 3'd3, 1'b1, 1'b1,
                              20'h0, 3'd0, 1'b0, 1'b0));
    tick(); wr_entry(4'd5, mk(19'h00050, 8'd5, 1'b0, 20'h0, 3'd0, 1'b0, 1'b0,
                              20'h0, 3'd0, 1'b0, 1'b0));
    tick(); req_data(32'h0020_0123, 1'b0, '{32'h0AAA_A123, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b1);
            req_probe(19'h00100, '{1'b0, 4'd2});
    tick(); req_probe(19'h12345, '{1'b1, 4'd0});
    tick(); req_probe(19'h00040, '{1'b0, 4'd3});
    tick(); bus.asid = 8'd6; req_probe(19'h00040, '{1'b1, 4'd0});
    tick(); bus.asid = 8'd5; req_probe(19'h00050, '{1'b0, 4'd5});
    // Probe concurrent with write sees the pre-write entry.
    tick(); wr_entry(4'd6, mk(19'h00060, 8'd5, 1'b0, 20'h1, 3'd3, 1'b1, 1'b1,
                              20'h0, 3'd0, 1'b0, 1'b0));
            req_probe(19'h00060, '{1'b1, 4'd0});
    tick(); req_probe(19'h00060, '{1'b0, 4'd6});

    // Reset pulsed during the second of three back-to-back requests.
    tick(); req_data(32'h0008_0ABC, 1'b0, '{32'h5432_1ABC, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b1);
    tick(); req_data(32'h0008_0ABC, 1'b0, '{32'h0, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b0);
            resetn = 1'b0;
            #1;
            check("ok_in_reset", 64'({bus.data_ok, bus.data_paddr}), 64'(0));
    tick(); resetn = 1'b1;
            req_data(32'h0008_0ABC, 1'b0, '{32'h0, 1'b0, 1'b1, 1'b0, 1'b0}, 1'b1);
    tick(); tick(); tick();
    check("queues_drained", 64'(inst_q.size() + data_q.size() + probe_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tlb_mmu.md
Name: tlb_mmu

Overview:
- Parametrised successor to the fixed-mapping address translator; sits between the pipeline fetch/memory stages and the cache/bus interface.
- kseg0/kseg1 addresses are direct-mapped. kuseg/kseg2/kseg3 addresses are translated through a fully-associative, software-managed TLB of TLB_ENTRIES dual-page entries.
- Serves an instruction channel and a data channel in parallel.
- Provides CP0 write (TLBWI/TLBWR), read (TLBR) and probe (TLBP) ports, and raises refill/invalid/modified exceptions.

Parameters:
TLB_ENTRIES, 16, number of TLB entries (power of two, 2..32)
ASID_W, 8, ASID width
IDX_W, $clog2(TLB_ENTRIES), index width (derived, not overridable)

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
asid  in  ASID_W  current ASID (CP0 EntryHi.ASID)
inst_req  in  1  instruction lookup request
inst_vaddr  in  32  instruction virtual address
inst_ok  out  1  instruction result valid (one-cycle pulse)
inst_paddr  out  32  instruction physical address
inst_uncached  out  1  access is uncached
inst_refill  out  1  TLB refill exception
inst_invalid  out  1  TLB invalid exception
data_req  in  1  data lookup request
data_wr  in  1  lookup is a store
data_vaddr  in  32  data virtual address
data_ok  out  1  data result valid (one-cycle pulse)
data_paddr  out  32  data physical address
data_uncached  out  1  access is uncached
data_refill  out  1  TLB refill exception
data_invalid  out  1  TLB invalid exception
data_modified  out  1  store to clean page
tlb_we  in  1  write entry
tlb_widx  in  IDX_W  write index
tlb_wentry  in  78  packed entry {VPN2[18:0], ASID, G, PFN0[19:0], C0[2:0], D0, V0, PFN1[19:0], C1[2:0], D1, V1}
tlbr_idx  in  IDX_W  read index
tlbr_entry  out  78  registered read data
tlbp_req  in  1  probe using probe_vpn2 and asid
probe_vpn2  in  19  probe VPN2
tlbp_ok  out  1  probe result valid (pulse)
tlbp_miss  out  1  probe found no match (EntryHi/Index.P)
tlbp_idx  out  IDX_W  matching index

Behaviour:
- Reset (async, resetn=0): all entries cleared (V0=V1=0, G=0, fields 0). All outputs 0, including tlbr_entry and tlbp_idx.
- Segment decode on vaddr[31:29]:
  - 100 (kseg0): paddr={3'b0,va[28:0]}, cached.
  - 101 (kseg1): same paddr, uncached.
  - Everything else is mapped.
- Match rule: entry.VPN2==va[31:13] && (entry.G || entry.ASID==asid). If several entries match, the lowest index wins.
- Page select: va[12]=0 picks PFN0/C0/D0/V0, va[12]=1 picks PFN1/C1/D1/V1.
- Mapped paddr={PFN, va[11:0]}. Uncached iff C==3'd2.
- Exception priority, evaluated per channel:
  1. No match -> refill.
  2. Match with V=0 -> invalid.
  3. data_wr=1 with D=0 -> modified.
  - On any exception the channel's paddr=0 and uncached=0.
  - Unmapped segments never raise exceptions.
- Latency: exactly 1 cycle. A request in cycle N yields ok=1 in N+1, with results held until the next ok.
  - Back-to-back requests are allowed, one result per cycle.
  - No stall or back-pressure.
  - ok is 0 in any cycle following a cycle with req=0.
- The channels are independent. Both may hit the same entry in the same cycle.
- Write: on a clock edge with tlb_we=1, entry[tlb_widx] is updated.
  - A lookup or probe in the same cycle sees the pre-write contents.
  - A lookup in the next cycle sees the new contents.
- TLBR: tlbr_entry registers entry[tlbr_idx] every cycle (1-cycle latency). A write to the same index in the same cycle returns the old value.
- TLBP: 1-cycle latency, matched on VPN2+ASID/G only (V ignored).
  - On a miss: tlbp_miss=1, tlbp_idx=0.
  - A probe concurrent with a write sees pre-write contents.
- Reset asserted mid-request: pending ok is dropped and the TLB is cleared. The first request after reset deasserts completes normally.

Decomposition:
- Shared package mmu_pkg holds:
  - Segment constants: KSEG0=3'b100, KSEG1=3'b101.
  - Entry field offsets/widths and the 78-bit entry typedef.
  - Exception code constants: TLBL/TLBS/MOD.
  - Uncached C value 3'd2.
- Sub-module tlb_lookup: purely combinational match/priority-encode/page-select. Instantiated three times (inst, data, probe).
- tlb_mmu holds the entry array, registers, and the write/read/probe logic.

Test Plan:
- Reset, then inst_req with va=0x9FC00000 -> next cycle inst_ok=1, paddr=0x1FC00000, uncached=0; va=0xBFC00004 -> paddr=0x1FC00004, uncached=1.
- Write idx3 {VPN2=0x00040, ASID=5, G=0, PFN0=0x12345, C0=3, D0=1, V0=1}, asid=5, data load va=0x00080ABC -> paddr=0x12345ABC; same access with asid=6 -> data_refill=1, paddr=0.
- Same entry, load va=0x00081ABC (odd page, V1=0) -> data_invalid=1. Store to an even page with D0=0 -> data_modified=1 and no refill/invalid.
- tlb_we to idx3 and inst_req to the matching va in the same cycle -> result uses the old entry. Repeat the request next cycle -> result uses the new entry.
- Identical VPN2 written at idx2 and idx7 with G=1 -> lookup returns idx2's PFN. tlbp_req for that VPN2 -> tlbp_miss=0, tlbp_idx=2. Probe of an unused VPN2 -> tlbp_miss=1, tlbp_idx=0.
- Back-to-back data_req for 3 cycles with resetn pulsed low during the 2nd -> no ok during reset, TLB cleared, and the 3rd request to a mapped va gives refill.
